// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter
// between N_REQ byte producers, with start-acknowledge timeout recovery.
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 512,
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW = $clog2(START_TIMEOUT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic [GW-1:0]      grant_id,
  output logic               active,
  output logic               timeout_err
);

  // One-hot encoding so tx_start is a flop output with no decode glitches.
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    LOAD      = 5'b00010,
    START     = 5'b00100,
    WAIT_DONE = 5'b01000,
    RELEASE   = 5'b10000
  } state_t;

  localparam int               START_BIT = 2;
  localparam logic [CW-1:0]    CNT_LAST  = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0]    REL_LAST  = CW'(1);
  localparam logic [GW-1:0]    PTR_LAST  = GW'(N_REQ - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [GW-1:0] ptr_q;
  logic [GW-1:0] winner;
  logic          win_found;
  logic [7:0]    sel_byte;
  logic          grant_ok;
  logic          timeout_hit;

  // Search upward from ptr with wrap; first valid requester wins.
  always_comb begin
    int            s;
    logic [GW-1:0] idx;
    winner    = ptr_q;
    win_found = 1'b0;
    s         = 0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      s = int'(ptr_q) + k;
      if (s >= N_REQ) s = s - N_REQ;
      idx = GW'(s);
      if (!win_found && req_valid[idx]) begin
        winner    = idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == GW'(i)) sel_byte = req_data[8*i +: 8];
    end
  end

  assign grant_ok    = win_found && !tx_busy;
  assign timeout_hit = !tx_busy && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (grant_ok) state_d = LOAD;
      LOAD:      state_d = START;
      START: begin
        // busy wins over a simultaneous timeout
        if (tx_busy)          state_d = WAIT_DONE;
        else if (timeout_hit) state_d = RELEASE;
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      RELEASE:   if (cnt_q == REL_LAST) state_d = START;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    active    = (state_q != IDLE);
    tx_start  = state_q[START_BIT];
    req_ready = '0;
    if (state_q == LOAD) req_ready[grant_id] = 1'b1;
  end

  // The counter restarts on every state change: START uses it for the
  // timeout, RELEASE for its two-cycle low period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      ptr_q       <= '0;
      grant_id    <= '0;
      tx_data     <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      if (state_d != state_q)  cnt_q <= '0;
      else if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CW'(1);
      timeout_err <= (state_q == START) && timeout_hit;
      if (state_q == IDLE && grant_ok) grant_id <= winner;
      if (state_q == LOAD) begin
        tx_data <= sel_byte;
        ptr_q   <= (grant_id == PTR_LAST) ? '0 : grant_id + GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a
// transmitter model that latches bytes on a 2-flop start edge detector.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int TO    = 16;
  localparam int FRAME = 20;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;
  logic           timeout_err;

  uart_tx_arbiter #(.N_REQ(N), .START_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter model
  logic       model_en = 1'b1;
  logic       force_busy = 1'b0;
  logic       s1 = 1'b0, s2 = 1'b0, m_busy = 1'b0;
  int         m_cnt = 0;
  int         hold_bad = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] got_q[$];

  assign tx_busy = force_busy | m_busy;

  always @(posedge clk) begin
    s1 <= tx_start;
    s2 <= s1;
    if (m_busy) begin
      if (active && tx_data !== m_byte) hold_bad <= hold_bad + 1;
      if (m_cnt == 1) m_busy <= 1'b0;
      m_cnt <= m_cnt - 1;
    end else if (model_en && s1 && !s2) begin
      m_busy <= 1'b1;
      m_cnt  <= FRAME;
      m_byte <= tx_data;
      got_q.push_back(tx_data);
    end
  end

  // Scoreboard and producer state
  logic [7:0] src_bytes [N][8];
  int         src_len [N];
  int         src_idx [N];
  logic [7:0] exp_q[$];
  int         grant_q[$], to_q[$], turn_q[$], low_q[$];
  int         cyc = 0, fall_t = -1000, low_run = 0, rr_bad = 0, got_base = 0;
  logic       prev_busy = 1'b0, prev_start = 1'b0;
  int         errors = 0, checks = 0;

  task automatic set_src(input int i, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) src_bytes[i][k] = base + 8'(k);
    src_len[i] = n;
    src_idx[i] = 0;
  endtask

  task automatic step();
    int id;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (src_idx[i] < src_len[i]);
      req_data[8*i +: 8] = req_valid[i] ? src_bytes[i][src_idx[i]] : 8'h00;
    end
    if (req_ready != '0) begin
      if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) rr_bad++;
      id = 0;
      for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
      grant_q.push_back(id);
      exp_q.push_back(src_bytes[id][src_idx[id]]);
      src_idx[id]++;
    end
    if (timeout_err) to_q.push_back(cyc);
    if (prev_busy && !tx_busy) fall_t = cyc;
    if (tx_start && !prev_start) begin
      turn_q.push_back(cyc - fall_t);
      low_q.push_back(low_run);
    end
    low_run    = tx_start ? 0 : low_run + 1;
    prev_busy  = tx_busy;
    prev_start = tx_start;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin src_len[i] = 0; src_idx[i] = 0; end
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    exp_q.delete(); grant_q.delete(); to_q.delete(); turn_q.delete(); low_q.delete();
    rr_bad = 0; fall_t = -1000; low_run = 0; got_base = got_q.size();
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (src_idx[i] < src_len[i]) return 1'b0;
    return !active && !tx_busy && (got_q.size() - got_base == exp_q.size());
  endfunction

  task automatic run_until_done(input int max, output bit ok);
    ok = 1'b0;
    for (int s = 0; s < max; s++) begin
      step();
      if (all_done()) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++; if (tx_start !== 1'b0)     begin errors++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00)     begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (req_ready !== 4'b0)    begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (grant_id !== 2'd0)     begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    checks++; if (active !== 1'b0)       begin errors++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (timeout_err !== 1'b0)  begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    int h0;
    do_reset();
    h0 = hold_bad;
    set_src(2, 1, 8'hA5);
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_early_ready got=%b exp=0000", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    checks++; if (grant_id !== 2'd2)     begin errors++; $display("FAIL single_grant_id got=%0d exp=2", grant_id); end
    step();
    checks++; if (tx_start !== 1'b1)     begin errors++; $display("FAIL single_tx_start got=%b exp=1", tx_start); end
    checks++; if (tx_data !== 8'hA5)     begin errors++; $display("FAIL single_tx_data got=%h exp=a5", tx_data); end
    run_until_done(200, ok);
    checks++; if (ok !== 1'b1)           begin errors++; $display("FAIL single_done got=%b exp=1", ok); end
    checks++; if (got_q.size() - got_base != 1) begin errors++; $display("FAIL single_frames got=%0d exp=1", got_q.size() - got_base); end
    checks++; if (got_q[got_base] !== exp_q[0]) begin errors++; $display("FAIL single_byte got=%h exp=%h", got_q[got_base], exp_q[0]); end
    checks++; if (hold_bad != h0)        begin errors++; $display("FAIL single_hold got=%0d exp=%0d", hold_bad, h0); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    set_src(0, 1, 8'h11);
    set_src(1, 1, 8'h22);
    run_until_done(400, ok);
    checks++; if (ok !== 1'b1)          begin errors++; $display("FAIL simul_done got=%b exp=1", ok); end
    checks++; if (grant_q.size() != 2)  begin errors++; $display("FAIL simul_handshakes got=%0d exp=2", grant_q.size()); end
    checks++; if (grant_q[0] != 0 || grant_q[1] != 1) begin errors++; $display("FAIL simul_order got=%0d,%0d exp=0,1", grant_q[0], grant_q[1]); end
    checks++; if (got_q[got_base] !== 8'h11)   begin errors++; $display("FAIL simul_byte0 got=%h exp=11", got_q[got_base]); end
    checks++; if (got_q[got_base+1] !== 8'h22) begin errors++; $display("FAIL simul_byte1 got=%h exp=22", got_q[got_base+1]); end
    checks++; if (rr_bad != 0)          begin errors++; $display("FAIL simul_ready_onehot got=%0d exp=0", rr_bad); end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 2, 8'(8'h30 + 16*i));
    run_until_done(1500, ok);
    checks++; if (ok !== 1'b1)         begin errors++; $display("FAIL fair_done got=%b exp=1", ok); end
    checks++; if (grant_q.size() != 8) begin errors++; $display("FAIL fair_handshakes got=%0d exp=8", grant_q.size()); end
    checks++; if (turn_q.size() != 8)  begin errors++; $display("FAIL fair_starts got=%0d exp=8", turn_q.size()); end
    for (int k = 0; k < 8 && k < grant_q.size(); k++) begin
      checks++; if (grant_q[k] != k % N) begin errors++; $display("FAIL fair_grant[%0d] got=%0d exp=%0d", k, grant_q[k], k % N); end
      checks++; if (got_q[got_base+k] !== exp_q[k]) begin errors++; $display("FAIL fair_byte[%0d] got=%h exp=%h", k, got_q[got_base+k], exp_q[k]); end
    end
    for (int k = 1; k < turn_q.size(); k++) begin
      checks++; if (turn_q[k] != 3) begin errors++; $display("FAIL fair_turnaround[%0d] got=%0d exp=3", k, turn_q[k]); end
      checks++; if (low_q[k] < 2)   begin errors++; $display("FAIL fair_low_gap[%0d] got=%0d exp>=2", k, low_q[k]); end
    end
    checks++; if (rr_bad != 0)         begin errors++; $display("FAIL fair_ready_onehot got=%0d exp=0", rr_bad); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    model_en = 1'b0;
    set_src(1, 1, 8'h77);
    repeat (4*(TO+2) + 10) step();
    checks++; if (to_q.size() < 3)     begin errors++; $display("FAIL timeout_pulses got=%0d exp>=3", to_q.size()); end
    for (int k = 1; k < to_q.size(); k++) begin
      checks++; if (to_q[k] - to_q[k-1] != TO + 2) begin errors++; $display("FAIL timeout_period[%0d] got=%0d exp=%0d", k, to_q[k] - to_q[k-1], TO + 2); end
    end
    for (int k = 1; k < low_q.size(); k++) begin
      checks++; if (low_q[k] != 2) begin errors++; $display("FAIL timeout_low[%0d] got=%0d exp=2", k, low_q[k]); end
    end
    checks++; if (grant_q.size() != 1) begin errors++; $display("FAIL timeout_handshakes got=%0d exp=1", grant_q.size()); end
    model_en = 1'b1;
    run_until_done(300, ok);
    checks++; if (ok !== 1'b1)         begin errors++; $display("FAIL timeout_recover got=%b exp=1", ok); end
    checks++; if (got_q[got_base] !== 8'h77) begin errors++; $display("FAIL timeout_byte got=%h exp=77", got_q[got_base]); end
    checks++; if (grant_q.size() != 1) begin errors++; $display("FAIL timeout_final_handshakes got=%0d exp=1", grant_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found;
    int n0;
    do_reset();
    set_src(1, 1, 8'h41);
    found = 1'b0;
    for (int s = 0; s < 50 && !found; s++) begin
      step();
      found = tx_busy && active && !tx_start;
    end
    checks++; if (found !== 1'b1)       begin errors++; $display("FAIL rmid_reach_wait got=%b exp=1", found); end
    set_src(0, 1, 8'h40);
    set_src(3, 1, 8'h43);
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if (tx_start !== 1'b0)    begin errors++; $display("FAIL rmid_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL rmid_tx_data got=%h exp=00", tx_data); end
    checks++; if (req_ready !== 4'b0)   begin errors++; $display("FAIL rmid_req_ready got=%b exp=0000", req_ready); end
    checks++; if (grant_id !== 2'd0)    begin errors++; $display("FAIL rmid_grant_id got=%0d exp=0", grant_id); end
    checks++; if (active !== 1'b0)      begin errors++; $display("FAIL rmid_active got=%b exp=0", active); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_timeout_err got=%b exp=0", timeout_err); end
    checks++; if (tx_busy !== 1'b1)     begin errors++; $display("FAIL rmid_frame_kept got=%b exp=1", tx_busy); end
    n0 = grant_q.size();
    for (int s = 0; s < 50 && tx_busy; s++) step();
    checks++; if (grant_q.size() != n0) begin errors++; $display("FAIL rmid_grant_while_busy got=%0d exp=%0d", grant_q.size(), n0); end
    run_until_done(300, ok);
    checks++; if (ok !== 1'b1)          begin errors++; $display("FAIL rmid_done got=%b exp=1", ok); end
    checks++; if (grant_q.size() != 3 || grant_q[1] != 0 || grant_q[2] != 3) begin errors++; $display("FAIL rmid_order got=n%0d %0d,%0d exp=n3 0,3", grant_q.size(), grant_q[1], grant_q[2]); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (got_q[got_base+k] !== exp_q[k]) begin errors++; $display("FAIL rmid_byte[%0d] got=%h exp=%h", k, got_q[got_base+k], exp_q[k]); end
    end
  endtask

  task automatic test_busy_idle();
    bit ok;
    int w;
    do_reset();
    force_busy = 1'b1;
    set_src(3, 1, 8'h5C);
    repeat (6) step();
    checks++; if (grant_q.size() != 0) begin errors++; $display("FAIL bidle_no_ready got=%0d exp=0", grant_q.size()); end
    checks++; if (active !== 1'b0)     begin errors++; $display("FAIL bidle_active got=%b exp=0", active); end
    force_busy = 1'b0;
    w = 0;
    while (grant_q.size() == 0 && w < 10) begin step(); w++; end
    checks++; if (!(w >= 1 && w <= 2)) begin errors++; $display("FAIL bidle_latency got=%0d exp=1..2", w); end
    checks++; if (grant_q.size() != 1 || grant_q[0] != 3) begin errors++; $display("FAIL bidle_grant got=n%0d id%0d exp=n1 id3", grant_q.size(), grant_q[0]); end
    run_until_done(300, ok);
    checks++; if (ok !== 1'b1 || got_q[got_base] !== 8'h5C) begin errors++; $display("FAIL bidle_frame got=%b/%h exp=1/5c", ok, got_q[got_base]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_busy_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the 8-bit UART transmitter between N_REQ byte producers, such as the command-processor reply path and status/debug sources. It accepts one byte per valid/ready handshake from the winning requester and drives the transmitter's level-sensitive start input. It tracks the transmitter's busy flag through a full frame before granting the next byte. A start timeout recovers from a transmitter that never acknowledges.

## Interface
- N_REQ, 4, number of requesters (2..8)
- START_TIMEOUT, 512, clk cycles allowed in START for tx_busy to rise (must exceed one baud period + 4)
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-low; clock clk
- req_valid  in  N_REQ  per-requester byte valid; once high, must stay high with stable data until its req_ready
- req_data  in  8*N_REQ  byte of requester i at [8i+7:8i]
- req_ready  out  N_REQ  one-hot, one-cycle pulse; byte of that requester transferred this cycle
- tx_start  out  1  to transmitter start input (rising edge requests a frame)
- tx_data  out  8  to transmitter data input, held stable for the whole frame
- tx_busy  in  1  transmitter busy flag
- grant_id  out  clog2(N_REQ)  index of current/last granted requester
- active  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse when START times out

## Operation
- States: IDLE, LOAD, START, WAIT_DONE, RELEASE. All are registered, and there is one transition per clk.
- IDLE:
  - If any req_valid is high and tx_busy is 0, pick the winner by round-robin and register it into grant_id. Go to LOAD.
  - If tx_busy is 1, stay in IDLE. No grant is made.
- Round-robin: search starts at ptr and moves upward with wrap to 0. The first valid requester wins. ptr resets to 0, so requester 0 has priority after reset.
- LOAD:
  - req_ready[grant_id] = 1 for exactly this cycle.
  - tx_data <= byte of grant_id.
  - ptr <= (grant_id+1) mod N_REQ.
  - Go to START.
- START:
  - tx_start = 1 and the timeout counter runs.
  - If tx_busy = 1, go to WAIT_DONE.
  - If the counter reaches START_TIMEOUT-1 with tx_busy still 0, pulse timeout_err and go to RELEASE.
- RELEASE: tx_start = 0 for 2 cycles (a counter sized for a low level the transmitter's 2-flop edge detector can see). Then return to START with the same byte and the counter cleared.
- WAIT_DONE: tx_start = 0. When tx_busy = 0, go to IDLE.
- req_ready is never asserted outside LOAD. The number of handshakes equals the number of frames started.
- tx_start is registered and glitch-free. It is high only in START.
- Reset values: tx_start 0, tx_data 0x00, req_ready 0, grant_id 0, active 0, timeout_err 0, ptr 0, state IDLE, timeout counter 0.
- Reset mid-operation: all registers take their reset values at the next clk edge. A frame already started in the transmitter is not aborted. The next grant waits in IDLE until tx_busy = 0.
- Dropping req_valid before ready is a protocol violation. The block does not need to handle it.

## Timing
- Arbitration latency: a request seen in IDLE gives req_ready 1 cycle later (LOAD), and tx_start rises 2 cycles after the IDLE decision.
- tx_start stays high until the first cycle tx_busy = 1 is sampled, then falls on the next edge.
- tx_busy rise can lag tx_start by up to one baud period + 3 cycles. This is why START_TIMEOUT must exceed it.
- Turnaround: after tx_busy falls, there is 1 cycle in IDLE before the next LOAD. With continuous requests there are 3 clk cycles between tx_busy falling and the next tx_start rising edge.
- tx_start is low for at least 2 consecutive cycles between any two rising edges. WAIT_DONE or RELEASE guarantees this.
- Simultaneous events:
  - New req_valid during LOAD/START/WAIT_DONE waits for IDLE.
  - tx_busy rising in the same cycle the counter hits START_TIMEOUT-1: busy wins, giving WAIT_DONE with no timeout_err.
- Counter width is clog2(START_TIMEOUT). It clears on entry to START and does not wrap.

## Test plan
- Single byte: req_valid[2] = 1, data 0xA5, transmitter idle. Expect req_ready[2] 1 cycle later, tx_data = 0xA5, tx_start high until busy, and one frame. active falls after tx_busy falls.
- Simultaneous requests: requesters 0 and 1 valid from reset with 0x11 and 0x22. Expect grant order 0 then 1, serial bytes 0x11 then 0x22, and exactly one req_ready pulse each.
- Fairness: all 4 requesters held valid for 8 bytes. Expect grant sequence 0,1,2,3,0,1,2,3 with no requester granted twice while another waits.
- Timeout: tx_busy model tied to 0. Expect timeout_err pulses every START_TIMEOUT+2 cycles, tx_start low for 2 cycles between pulses, and no further req_ready.
- Reset mid-frame: assert reset for 1 cycle during WAIT_DONE. Expect all outputs at reset values next cycle and no grant while tx_busy = 1. Grant resumes from requester 0 after busy falls.
- Busy in IDLE: tx_busy forced 1 with req_valid[3] = 1. Expect no req_ready. Release busy and expect req_ready[3] 2 cycles later.
